// File: rtl/tlb_probe_read.sv
// Sequential TLBP/TLBR engine on the read-back side of the TLB array.
// TLBP scans entries lowest-first through a registered read port; TLBR copies one entry out.
module tlb_probe_read #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int ENTRY_W     = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               op_i,
    input  logic [31:0]        index_i,
    input  logic [31:0]        entryhi_i,
    input  logic               flush_i,
    output logic [IDX_W-1:0]   tlb_rd_idx_o,
    input  logic [ENTRY_W-1:0] tlb_rd_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               index_we_o,
    output logic [31:0]        index_o,
    output logic               entry_we_o,
    output logic [31:0]        entryhi_o,
    output logic [31:0]        entrylo0_o,
    output logic [31:0]        entrylo1_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

    // Same VPN2-only match rule as the translate path: ASID and G are ignored.
    function automatic logic vpn2_match(input logic [ENTRY_W-1:0] entry, input logic [18:0] vpn2);
        return (entry[ENTRY_W-1 -: 19] == vpn2);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [18:0]      vpn2_r;
    logic             op_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [IDX_W-1:0] cmp_idx_r;
    logic             cmp_vld_r;
    logic             rd_phase_r;
    logic [31:0]      index_r;
    logic [31:0]      entryhi_r;
    logic [31:0]      entrylo0_r;
    logic [31:0]      entrylo1_r;
    logic             accept_s;
    logic             hit_s;
    logic             last_s;
    logic             unused_s;

    assign accept_s = start_i & ~flush_i;
    assign hit_s    = cmp_vld_r & vpn2_match(tlb_rd_data_i, vpn2_r);
    assign last_s   = cmp_vld_r & (cmp_idx_r == LAST_IDX);
    assign unused_s = &{1'b0, entryhi_i[12:0], index_i[31:IDX_W]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = op_i ? READ : PROBE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PROBE: begin
                if (flush_i) begin
                    state_next_s = IDLE;
                end else if (hit_s || last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = PROBE;
                end
            end
            READ: begin
                if (flush_i) begin
                    state_next_s = IDLE;
                end else if (rd_phase_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = READ;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Outputs; a flush in the DONE cycle masks the completion pulse and strobes.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        index_we_o = 1'b0;
        entry_we_o = 1'b0;
        if (state_r != IDLE) begin
            busy_o = 1'b1;
        end else begin
            busy_o = 1'b0;
        end
        if ((state_r == DONE) && !flush_i) begin
            done_o     = 1'b1;
            index_we_o = ~op_r;
            entry_we_o = op_r;
        end else begin
            done_o     = 1'b0;
            index_we_o = 1'b0;
            entry_we_o = 1'b0;
        end
    end

    // Datapath: request latches, scan address/compare pipeline, result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpn2_r     <= 19'd0;
            op_r       <= 1'b0;
            rd_idx_r   <= '0;
            cmp_idx_r  <= '0;
            cmp_vld_r  <= 1'b0;
            rd_phase_r <= 1'b0;
            index_r    <= 32'd0;
            entryhi_r  <= 32'd0;
            entrylo0_r <= 32'd0;
            entrylo1_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        vpn2_r     <= entryhi_i[31:13];
                        op_r       <= op_i;
                        rd_idx_r   <= op_i ? index_i[IDX_W-1:0] : '0;
                        cmp_idx_r  <= '0;
                        cmp_vld_r  <= 1'b0;
                        rd_phase_r <= 1'b0;
                    end
                end
                PROBE: begin
                    // rd_idx_r doubles as the scan counter and saturates on the last entry.
                    rd_idx_r  <= (rd_idx_r == LAST_IDX) ? rd_idx_r : rd_idx_r + IDX_W'(1);
                    cmp_idx_r <= rd_idx_r;
                    cmp_vld_r <= 1'b1;
                    if (!flush_i && hit_s) begin
                        index_r <= {1'b0, {(31 - IDX_W){1'b0}}, cmp_idx_r};
                    end else if (!flush_i && last_s) begin
                        index_r <= 32'h8000_0000;
                    end
                end
                READ: begin
                    rd_phase_r <= 1'b1;
                    if (rd_phase_r && !flush_i) begin
                        entryhi_r  <= tlb_rd_data_i[95:64];
                        entrylo0_r <= tlb_rd_data_i[63:32];
                        entrylo1_r <= tlb_rd_data_i[31:0];
                    end
                end
                DONE: begin
                    cmp_vld_r <= 1'b0;
                end
                default: begin
                    cmp_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign tlb_rd_idx_o = rd_idx_r;
    assign index_o      = index_r;
    assign entryhi_o    = entryhi_r;
    assign entrylo0_o   = entrylo0_r;
    assign entrylo1_o   = entrylo1_r;

endmodule
